// File: rtl/dwt_mul_scheduler.sv
// Issues samples x coefficient to an external FP32 multiplier and buffers results.
// Define DWT_MUL_STICKY_FLAGS_EN to accumulate popped flags into sticky_flags.
module dwt_mul_scheduler #(
    parameter int MUL_LAT    = 7,
    parameter int FLAG_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_sample,
    input  logic [2:0]  in_sel,
    input  logic [7:0]  in_tag,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_exc,
    input  logic        mul_ovf,
    input  logic        mul_unf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_tag,
    output logic [2:0]  out_flags,
    output logic [2:0]  sticky_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FD = MUL_LAT - FLAG_LAT;
    localparam int EW = 43;

    logic [31:0]    coef [8];
    logic [CW-1:0]  credit;
    logic [CW-1:0]  count;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [EW-1:0]  head;
    logic [MUL_LAT:0] vld;
    logic [7:0]     tag_p [MUL_LAT+1];
    logic [2:0]     tail_flags;
    logic           accept;
    logic           pop;
    logic           push;

    assign in_ready  = credit < CW'(FIFO_DEPTH);
    assign accept    = in_valid & in_ready;
    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign push      = vld[MUL_LAT];

    // Gate the head so an empty FIFO presents zeros, not stale storage.
    assign head      = out_valid ? mem[rptr] : '0;
    assign out_data  = head[42:11];
    assign out_tag   = head[10:3];
    assign out_flags = head[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                coef[i] <= '0;
            end
        end else if (cfg_we) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= in_sample;
            mul_b <= coef[in_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[MUL_LAT-1:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= in_tag;
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_p[k] <= tag_p[k-1];
        end
    end

    // Flags arrive early; delay them so they land with the result tail.
    if (FD > 0) begin : g_flag_pipe
        logic [2:0] fp [FD];
        always_ff @(posedge clk) begin
            fp[0] <= {mul_exc, mul_ovf, mul_unf};
            for (int k = 1; k < FD; k++) begin
                fp[k] <= fp[k-1];
            end
        end
        assign tail_flags = fp[FD-1];
    end else begin : g_flag_direct
        assign tail_flags = {mul_exc, mul_ovf, mul_unf};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {mul_result, tag_p[MUL_LAT], tail_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Credit covers in-flight plus buffered results, so a push always fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= '0;
        end else if (accept && !pop) begin
            credit <= credit + CW'(1);
        end else if (!accept && pop) begin
            credit <= credit - CW'(1);
        end
    end

`ifdef DWT_MUL_STICKY_FLAGS_EN
    logic [2:0] sticky_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (pop) begin
            sticky_q <= sticky_q | out_flags;
        end
    end
    assign sticky_flags = sticky_q;
`else
    assign sticky_flags = 3'b000;
`endif

endmodule

// File: tb/tb_dwt_mul_scheduler.sv
// Directed bench for dwt_mul_scheduler with a pipelined FP32 multiplier model.
// Multiplier raises ovf when its a operand equals OVF_SAMPLE.
module tb_dwt_mul_scheduler;

    localparam int ML    = 7;
    localparam int FL    = 3;
    localparam int DEPTH = 8;
    localparam logic [31:0] OVF_SAMPLE = 32'h3FA0_0000;
    localparam logic [31:0] ONE        = 32'h3F80_0000;
`ifdef DWT_MUL_STICKY_FLAGS_EN
    localparam logic [2:0] STICKY_EXP = 3'b010;
`else
    localparam logic [2:0] STICKY_EXP = 3'b000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sample = '0;
    logic [2:0]  in_sel = '0;
    logic [7:0]  in_tag = '0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_result;
    logic        mul_exc;
    logic        mul_ovf;
    logic        mul_unf;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_tag;
    logic [2:0]  out_flags;
    logic [2:0]  sticky_flags;

    int n_checks = 0;
    int n_fail   = 0;

    dwt_mul_scheduler #(
        .MUL_LAT(ML),
        .FLAG_LAT(FL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sample(in_sample),
        .in_sel(in_sel),
        .in_tag(in_tag),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_result(mul_result),
        .mul_exc(mul_exc),
        .mul_ovf(mul_ovf),
        .mul_unf(mul_unf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag),
        .out_flags(out_flags),
        .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    // Normal-number FP32 multiply, truncating; enough for the chosen vectors.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:0] == '0 || b[30:0] == '0) begin
            return {a[31] ^ b[31], 31'b0};
        end
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] samp(input int i);
        return ONE + (32'(i) << 15);
    endfunction

    logic [31:0] res_p [ML];
    logic [2:0]  flg_p [FL];

    always @(posedge clk) begin
        res_p[0] <= fpmul(mul_a, mul_b);
        for (int i = 1; i < ML; i++) res_p[i] <= res_p[i-1];
        flg_p[0] <= (mul_a == OVF_SAMPLE) ? 3'b010 : 3'b000;
        for (int i = 1; i < FL; i++) flg_p[i] <= flg_p[i-1];
    end

    assign mul_result = res_p[ML-1];
    assign {mul_exc, mul_ovf, mul_unf} = flg_p[FL-1];

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 3'd3;
        cfg_data = 32'h1234_5678;
        in_valid = 1'b1;
        in_sample = 32'h3F80_0000;
        in_sel = 3'd3;
        in_tag = 8'h77;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg_we = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        n_checks++;
        if ({out_data, out_tag, out_flags} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_out_fields: got %h/%h/%b want 0", out_data, out_tag, out_flags);
        end
        n_checks++;
        if (sticky_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sticky: got %b want 000", sticky_flags);
        end
        n_checks++;
        if ({mul_a, mul_b} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h/%h want 0/0", mul_a, mul_b);
        end
        // coef[3] write was issued under reset and must not have landed.
        in_valid = 1'b1;
        in_sample = 32'h4000_0000;
        in_sel = 3'd3;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (mul_a !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL reset_probe_a: got %h want 40000000", mul_a);
        end
        n_checks++;
        if (mul_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cfg_priority: got %h want 00000000", mul_b);
        end
    endtask

    task automatic test_single;
        int first;
        logic [31:0] d;
        logic [7:0]  t;
        logic [2:0]  f;
        first = -1;
        d = '0;
        t = '0;
        f = '0;
        do_reset;
        cfg_write(3'd2, 32'h4000_0000);
        for (int c = 0; c < ML + 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (c == 0);
            in_sample = 32'h3FC0_0000;
            in_sel = 3'd2;
            in_tag = 8'h11;
            if (c == 1) begin
                n_checks++;
                if (mul_a !== 32'h3FC0_0000 || mul_b !== 32'h4000_0000) begin
                    n_fail++;
                    $display("FAIL single_operands: got %h/%h want 3fc00000/40000000", mul_a, mul_b);
                end
            end
            if (out_valid && first < 0) begin
                first = c;
                d = out_data;
                t = out_tag;
                f = out_flags;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (first != ML + 2) begin
            n_fail++;
            $display("FAIL single_latency: got cycle %0d want %0d", first, ML + 2);
        end
        n_checks++;
        if (d !== 32'h4040_0000) begin
            n_fail++;
            $display("FAIL single_data: got %h want 40400000", d);
        end
        n_checks++;
        if (t !== 8'h11 || f !== 3'b000) begin
            n_fail++;
            $display("FAIL single_tag_flags: got %h/%b want 11/000", t, f);
        end
    endtask

    task automatic test_back_to_back;
        int idx;
        int nout;
        idx = 0;
        nout = 0;
        do_reset;
        cfg_write(3'd0, ONE);
        for (int c = 0; c < 40 && nout < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 6);
            in_sample = samp(idx + 40);
            in_sel = 3'd0;
            in_tag = 8'h40 + 8'(idx);
            if (out_valid) begin
                n_checks++;
                if (c != ML + 2 + nout || out_data !== samp(nout + 40) || out_tag !== 8'h40 + 8'(nout)) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got c=%0d %h/%h want c=%0d %h/%h", nout, c, out_data, out_tag,
                             ML + 2 + nout, samp(nout + 40), 8'h40 + 8'(nout));
                end
                nout++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (nout != 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 6", nout);
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int nout;
        idx = 0;
        nout = 0;
        do_reset;
        cfg_write(3'd0, ONE);
        for (int c = 0; c < 100 && nout < 10; c++) begin
            @(negedge clk);
            out_ready = (c >= 10);
            in_valid = (idx < 10);
            in_sample = samp(idx);
            in_sel = 3'd0;
            in_tag = 8'h20 + 8'(idx);
            if (c == 10) begin
                n_checks++;
                if (idx != 8 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_accepted: got %0d ready=%0b want 8 ready=0", idx, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== samp(nout) || out_tag !== 8'h20 + 8'(nout)) begin
                    n_fail++;
                    $display("FAIL bp_out%0d: got %h/%h want %h/%h", nout, out_data, out_tag,
                             samp(nout), 8'h20 + 8'(nout));
                end
                nout++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (nout != 10) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 10", nout);
        end
    endtask

    task automatic test_full_wrap;
        int idx;
        int nout;
        int extra;
        idx = 0;
        nout = 0;
        extra = 0;
        do_reset;
        cfg_write(3'd0, ONE);
        for (int c = 0; c < 150 && nout < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 25);
            in_valid = (idx < 20);
            in_sample = samp(idx + 8);
            in_sel = 3'd0;
            in_tag = 8'h60 + 8'(idx);
            if (c == 25) begin
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || idx != 8) begin
                    n_fail++;
                    $display("FAIL wrap_full: got v=%0b r=%0b n=%0d want v=1 r=0 n=8", out_valid, in_ready, idx);
                end
            end
            if (c == 26 || c == 27) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_ready_c%0d: got %0b want 1", c, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== samp(nout + 8) || out_tag !== 8'h60 + 8'(nout)) begin
                    n_fail++;
                    $display("FAIL wrap_out%0d: got %h/%h want %h/%h", nout, out_data, out_tag,
                             samp(nout + 8), 8'h60 + 8'(nout));
                end
                nout++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (nout != 20) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 20", nout);
        end
        for (int c = 0; c < 2 * ML; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL wrap_duplicate: got %0d extra outputs want 0", extra);
        end
    endtask

    task automatic test_flags;
        int idx;
        int nout;
        logic [31:0] fs [3];
        logic [2:0]  fexp;
        fs[0] = 32'h3F90_0000;
        fs[1] = OVF_SAMPLE;
        fs[2] = 32'h3FB0_0000;
        idx = 0;
        nout = 0;
        do_reset;
        cfg_write(3'd0, ONE);
        for (int c = 0; c < 40 && nout < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 3);
            in_sample = fs[idx < 3 ? idx : 0];
            in_sel = 3'd0;
            in_tag = 8'h04 + 8'(idx);
            if (out_valid) begin
                fexp = (nout == 1) ? 3'b010 : 3'b000;
                n_checks++;
                if (out_flags !== fexp || out_tag !== 8'h04 + 8'(nout) || out_data !== fs[nout]) begin
                    n_fail++;
                    $display("FAIL flags_out%0d: got %b/%h/%h want %b/%h/%h", nout, out_flags, out_tag,
                             out_data, fexp, 8'h04 + 8'(nout), fs[nout]);
                end
                if (nout == 1) begin
                    n_checks++;
                    if (sticky_flags !== 3'b000) begin
                        n_fail++;
                        $display("FAIL sticky_before: got %b want 000", sticky_flags);
                    end
                end
                if (nout == 2) begin
                    n_checks++;
                    if (sticky_flags !== STICKY_EXP) begin
                        n_fail++;
                        $display("FAIL sticky_after: got %b want %b", sticky_flags, STICKY_EXP);
                    end
                end
                nout++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (nout != 3 || sticky_flags !== STICKY_EXP) begin
            n_fail++;
            $display("FAIL sticky_persist: got n=%0d %b want n=3 %b", nout, sticky_flags, STICKY_EXP);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        do_reset;
        cfg_write(3'd0, ONE);
        for (int c = 0; c <= ML + 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (c < 5);
            in_sample = samp(c + 3);
            in_sel = 3'd0;
            in_tag = 8'h80 + 8'(c);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 8'h80) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got v=%0b tag=%h want v=1 tag=80", out_valid, out_tag);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_post_reset: got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
        end
        for (int c = 0; c < 2 * ML; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_stale_output: got %0d outputs want 0", seen);
        end
    endtask

    task automatic test_cfg_collision;
        int nout;
        logic [31:0] dexp;
        nout = 0;
        do_reset;
        cfg_write(3'd1, 32'h4000_0000);
        for (int c = 0; c < 40 && nout < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            cfg_we = (c == 0);
            cfg_addr = 3'd1;
            cfg_data = ONE;
            in_valid = (c < 2);
            in_sample = 32'h3FC0_0000;
            in_sel = 3'd1;
            in_tag = 8'h31 + 8'(c);
            if (c == 1) begin
                n_checks++;
                if (mul_b !== 32'h4000_0000) begin
                    n_fail++;
                    $display("FAIL coll_old_coef: got %h want 40000000", mul_b);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (mul_b !== ONE) begin
                    n_fail++;
                    $display("FAIL coll_new_coef: got %h want 3f800000", mul_b);
                end
            end
            if (out_valid) begin
                dexp = (nout == 0) ? 32'h4040_0000 : 32'h3FC0_0000;
                n_checks++;
                if (out_data !== dexp || out_tag !== 8'h31 + 8'(nout)) begin
                    n_fail++;
                    $display("FAIL coll_out%0d: got %h/%h want %h/%h", nout, out_data, out_tag,
                             dexp, 8'h31 + 8'(nout));
                end
                nout++;
            end
        end
        cfg_we = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (nout != 2) begin
            n_fail++;
            $display("FAIL coll_count: got %0d want 2", nout);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_full_wrap;
        test_flags;
        test_reset_mid;
        test_cfg_collision;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
